// File: rtl/pipelined_carry_add.sv
// pipelined_carry_add
//
// Pipelined WIDTH-bit adder built from NSEG = WIDTH/SEG_W ripple segments.
// Segment k is added in pipeline stage k using the carry registered by
// stage k-1. The upper operand segments travel alongside the partial sum
// until their own stage is reached. All stages advance together on
// en = out_ready | ~out_valid, which is also presented as in_ready.
//
// Optional feature (macro PCA_SUB_EN): adds a 'sub' input sampled with the
// operands. When it is set, the block computes a + ~b + 1 (a - b) and
// ignores cin. cout=1 then means "no borrow".
//
// Parameters:
//   WIDTH  operand/sum width, must be a positive multiple of SEG_W
//   SEG_W  bits added per pipeline stage
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid / in_ready   input handshake for a, b, cin (and sub)
//   a, b, cin             operands and carry-in
//   sub                   subtract select (PCA_SUB_EN builds only)
//   out_valid / out_ready output handshake for sum, cout, ovf
//   sum                   a + b + cin modulo 2^WIDTH
//   cout                  carry out of the MSB
//   ovf                   signed overflow (carry into MSB xor cout)
module pipelined_carry_add #(
  parameter int WIDTH = 32,
  parameter int SEG_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef PCA_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NSEG = (SEG_W > 0 && WIDTH >= SEG_W) ? (WIDTH / SEG_W) : 1;

  if (SEG_W <= 0 || WIDTH <= 0 || (WIDTH % SEG_W) != 0) begin : g_bad_cfg
    $error("pipelined_carry_add: WIDTH must be a positive multiple of SEG_W");
  end

  // Signed overflow from the MSB column: the carry into the MSB is
  // recovered as a ^ b ^ sum at that bit, then compared with the carry out.
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb,
                                      input logic sum_msb, input logic carry_out);
    logic carry_into_msb;
    carry_into_msb = a_msb ^ b_msb ^ sum_msb;
    return carry_into_msb ^ carry_out;
  endfunction

  // Stage-boundary chains: index k is the input of stage k, index NSEG the
  // pipeline output.
  logic [NSEG:0]    vld_c;
  logic [NSEG:0]    cry_c;
  logic [WIDTH-1:0] opa_c [NSEG];
  logic [WIDTH-1:0] opb_c [NSEG];
  logic [WIDTH-1:0] sum_c [NSEG+1];

  logic             en;
  logic [WIDTH-1:0] b_in;
  logic             c_in;

  assign en       = out_ready | ~out_valid;
  assign in_ready = en;

`ifdef PCA_SUB_EN
  // Subtraction is folded into the operands: invert b and force carry-in.
  always_comb begin
    b_in = b;
    c_in = cin;
    if (sub) begin
      b_in = ~b;
      c_in = 1'b1;
    end else begin
      b_in = b;
      c_in = cin;
    end
  end
`else
  // Addition only: operands enter the pipeline unchanged.
  always_comb begin
    b_in = b;
    c_in = cin;
  end
`endif

  assign vld_c[0] = in_valid;
  assign cry_c[0] = c_in;
  assign opa_c[0] = a;
  assign opb_c[0] = b_in;
  assign sum_c[0] = '0;

  for (genvar k = 0; k < NSEG; k++) begin : g_stage
    logic [SEG_W:0]   seg;
    logic [WIDTH-1:0] s_next;
    logic             vld_r;
    logic             cry_r;
    logic [WIDTH-1:0] sum_r;

    assign seg = {1'b0, opa_c[k][k*SEG_W +: SEG_W]}
               + {1'b0, opb_c[k][k*SEG_W +: SEG_W]}
               + {{SEG_W{1'b0}}, cry_c[k]};

    // Merge this stage's segment into the running low-order sum.
    always_comb begin
      s_next = sum_c[k];
      s_next[k*SEG_W +: SEG_W] = seg[SEG_W-1:0];
    end

    // Stage register: valid, carry and partial sum advance together on en.
    always_ff @(posedge clk) begin
      if (rst) begin
        vld_r <= 1'b0;
        cry_r <= 1'b0;
        sum_r <= '0;
      end else if (en) begin
        vld_r <= vld_c[k];
        cry_r <= seg[SEG_W];
        sum_r <= s_next;
      end
    end

    assign vld_c[k+1] = vld_r;
    assign cry_c[k+1] = cry_r;
    assign sum_c[k+1] = sum_r;

    if (k < NSEG - 1) begin : g_skew
      logic [WIDTH-1:0] a_r;
      logic [WIDTH-1:0] b_r;

      // Skewed operand copies carry the not-yet-added segments forward.
      always_ff @(posedge clk) begin
        if (rst) begin
          a_r <= '0;
          b_r <= '0;
        end else if (en) begin
          a_r <= opa_c[k];
          b_r <= opb_c[k];
        end
      end

      assign opa_c[k+1] = a_r;
      assign opb_c[k+1] = b_r;
    end else begin : g_tail
      logic ovf_r;

      // Overflow is resolved in the last stage, where the MSB column is added.
      always_ff @(posedge clk) begin
        if (rst) begin
          ovf_r <= 1'b0;
        end else if (en) begin
          ovf_r <= signed_ovf(opa_c[k][WIDTH-1], opb_c[k][WIDTH-1],
                              seg[SEG_W-1], seg[SEG_W]);
        end
      end

      assign ovf = ovf_r;
    end
  end

  assign out_valid = vld_c[NSEG];
  assign cout      = cry_c[NSEG];
  assign sum       = sum_c[NSEG];

endmodule
